// File: rtl/camera_pixel_binarizer_if.sv
// Pixel stream from the camera reader and the BRAM write port it turns into.
// master drives pixels and observes writes; slave is the binarizer.
interface camera_pixel_binarizer_if #(
  parameter int unsigned ADDR_W = 17
) ();
  logic [15:0]       pixel_in;
  logic              pixel_valid_in;
  logic              frame_done_in;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [11:0]       wr_data_out;
  logic              wr_en_out;

  modport master (
    output pixel_in, pixel_valid_in, frame_done_in,
    input  wr_addr_out, wr_data_out, wr_en_out
  );

  modport slave (
    input  pixel_in, pixel_valid_in, frame_done_in,
    output wr_addr_out, wr_data_out, wr_en_out
  );
endinterface

// File: rtl/camera_pixel_binarizer.sv
// Frame-latched colour filter, BRAM address generator and downsampled binary grid
// (one packed row per DS-line band, strict-majority dark cells).
module camera_pixel_binarizer #(
  parameter int unsigned H_PIX  = 320,
  parameter int unsigned V_PIX  = 240,
  parameter int unsigned DS     = 8,
  parameter int unsigned ADDR_W = 17,
  localparam int unsigned GW    = H_PIX / DS,
  localparam int unsigned GH    = V_PIX / DS,
  localparam int unsigned RW    = $clog2(GH),
  localparam int unsigned CW    = $clog2(DS * DS + 1),
  localparam int unsigned XW    = $clog2(H_PIX),
  localparam int unsigned YW    = $clog2(V_PIX)
) (
  input  logic                    pclk_in,
  input  logic                    reset,
  camera_pixel_binarizer_if.slave pix_if,
  input  logic [2:0]              mode_in,
  input  logic [3:0]              thresh_in,
  output logic [GW-1:0]           row_bits_out,
  output logic [RW-1:0]           row_idx_out,
  output logic                    row_valid_out,
  output logic                    grid_done_out,
  output logic                    frame_short_out,
  output logic                    overflow_out
);

  logic              in_rst_q;
  logic [2:0]        mode_q, mode_d, mode_san, mode_eff;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic              full_q, full_d, ovf_q, ovf_d;
  logic [11:0]       prev_q, prev_d, wr_data_q, wr_data_d, proc;
  logic [CW-1:0]     cnt_q [GW];
  logic [CW-1:0]     cnt_d [GW];
  logic [CW-1:0]     cnt_acc [GW];
  logic [GW-1:0]     sum_gt, row_bits_q, row_bits_d;
  logic [RW-1:0]     row_idx_q, row_idx_d;
  logic              wr_en_q, wr_en_d, row_valid_q, row_valid_d;
  logic              grid_done_q, grid_done_d, short_q, short_d;
  logic [3:0]        r, g, b;
  logic [4:0]        luma;
  logic              dark, accept, x_last, y_last, band_end;
  logic [31:0]       sum;
  logic              unused_pixel_bits;

  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] c);
    return (a >= c) ? a - c : c - a;
  endfunction

  assign unused_pixel_bits = ^{pix_if.pixel_in[11], pix_if.pixel_in[6:5], pix_if.pixel_in[0]};

  always_comb begin
    r        = pix_if.pixel_in[15:12];
    g        = pix_if.pixel_in[10:7];
    b        = pix_if.pixel_in[4:1];
    mode_san = (mode_in > 3'd5) ? 3'd0 : mode_in;
    // The first cycle out of reset uses the freshly sampled mode directly.
    mode_eff = in_rst_q ? mode_san : mode_q;
    luma     = 5'(r[3:2]) + 5'(g[3:1]) + 5'(b[3:2]);
    dark     = luma <= 5'(thresh_in);
    case (mode_eff)
      3'd1:    proc = {abs_diff(r, prev_q[11:8]), abs_diff(g, prev_q[7:4]),
                       abs_diff(b, prev_q[3:0])};
      3'd2:    proc = (r > 4'd8 && g < 4'd8 && b < 4'd8) ? 12'hF00 : 12'h000;
      3'd3:    proc = (g > 4'd8 && r < 4'd8 && b < 4'd8) ? 12'h0F0 : 12'h000;
      3'd4:    proc = (b > 4'd8 && r < 4'd8 && g < 4'd8) ? 12'h00F : 12'h000;
      3'd5:    proc = (luma > 5'(thresh_in)) ? 12'hFFF : 12'h000;
      default: proc = {r, g, b};
    endcase
  end

  always_comb begin
    accept   = pix_if.pixel_valid_in && !pix_if.frame_done_in && !full_q;
    x_last   = x_q == XW'(H_PIX - 1);
    y_last   = y_q == YW'(V_PIX - 1);
    band_end = x_last && ((32'(y_q) % DS) == DS - 1);
    sum      = '0;
    // Row bits include the closing pixel, so evaluate counts with it added.
    for (int unsigned c = 0; c < GW; c++) begin
      sum        = 32'(cnt_q[c]) + (((32'(x_q) / DS) == c) ? 32'(dark) : 32'd0);
      cnt_acc[c] = CW'(sum);
      sum_gt[c]  = sum > (DS * DS) / 2;
    end

    mode_d      = mode_eff;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    full_d      = full_q;
    ovf_d       = ovf_q;
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    row_bits_d  = row_bits_q;
    row_idx_d   = row_idx_q;
    row_valid_d = 1'b0;
    grid_done_d = 1'b0;
    short_d     = 1'b0;

    if (pix_if.frame_done_in) begin
      mode_d  = mode_san;
      short_d = (x_q != '0 || y_q != '0) && !full_q;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
      full_d  = 1'b0;
      ovf_d   = 1'b0;
      prev_d  = '0;
      for (int unsigned c = 0; c < GW; c++) cnt_d[c] = '0;
    end else if (pix_if.pixel_valid_in && full_q) begin
      ovf_d = 1'b1;
    end else if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = proc;
      addr_d    = addr_q + ADDR_W'(1);
      prev_d    = {r, g, b};
      cnt_d     = cnt_acc;
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d    = '0;
          full_d = 1'b1;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
      if (band_end) begin
        row_valid_d = 1'b1;
        row_bits_d  = sum_gt;
        row_idx_d   = RW'(32'(y_q) / DS);
        grid_done_d = (32'(y_q) / DS) == GH - 1;
        for (int unsigned c = 0; c < GW; c++) cnt_d[c] = '0;
      end
    end
  end

  always_ff @(posedge pclk_in) begin
    if (reset) begin
      in_rst_q    <= 1'b1;
      mode_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      prev_q      <= '0;
      for (int unsigned c = 0; c < GW; c++) cnt_q[c] <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      row_bits_q  <= '0;
      row_idx_q   <= '0;
      row_valid_q <= 1'b0;
      grid_done_q <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      in_rst_q    <= 1'b0;
      mode_q      <= mode_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      row_bits_q  <= row_bits_d;
      row_idx_q   <= row_idx_d;
      row_valid_q <= row_valid_d;
      grid_done_q <= grid_done_d;
      short_q     <= short_d;
    end
  end

  assign pix_if.wr_en_out   = wr_en_q;
  assign pix_if.wr_addr_out = wr_addr_q;
  assign pix_if.wr_data_out = wr_data_q;
  assign row_bits_out       = row_bits_q;
  assign row_idx_out        = row_idx_q;
  assign row_valid_out      = row_valid_q;
  assign grid_done_out      = grid_done_q;
  assign frame_short_out    = short_q;
  assign overflow_out       = ovf_q;

endmodule

// File: tb/tb_camera_pixel_binarizer.sv
// Bench for camera_pixel_binarizer on a 16x16 frame with 8x8 cells: vector table,
// directed corner sequences and random traffic against a frame-level model.
module tb_camera_pixel_binarizer;
  localparam int unsigned H = 16, V = 16, DS = 8, AW = 8;
  localparam int unsigned GW = H / DS, GH = V / DS, NPIX = H * V;

  logic          pclk_in = 1'b0;
  logic          reset;
  logic [2:0]    mode_in;
  logic [3:0]    thresh_in;
  logic [GW-1:0] row_bits_out;
  logic [0:0]    row_idx_out;
  logic          row_valid_out, grid_done_out, frame_short_out, overflow_out;

  camera_pixel_binarizer_if #(.ADDR_W(AW)) bus ();

  camera_pixel_binarizer #(.H_PIX(H), .V_PIX(V), .DS(DS), .ADDR_W(AW)) dut (
    .pclk_in        (pclk_in),
    .reset          (reset),
    .pix_if         (bus),
    .mode_in        (mode_in),
    .thresh_in      (thresh_in),
    .row_bits_out   (row_bits_out),
    .row_idx_out    (row_idx_out),
    .row_valid_out  (row_valid_out),
    .grid_done_out  (grid_done_out),
    .frame_short_out(frame_short_out),
    .overflow_out   (overflow_out)
  );

  always #5 pclk_in = ~pclk_in;

  int tests = 0, fails = 0;

  // Model state: pixels accepted this frame, previous pixel, latched mode, dark image.
  int            n;
  logic [11:0]   prev;
  int            mode;
  bit            dark_img [V][H];
  bit            e_wr_en, e_rv, e_gd, e_short, e_ovf;
  int            e_addr, e_idx;
  logic [11:0]   e_data;
  logic [GW-1:0] e_bits;

  int            writes_seen, rows_seen, gd_seen, short_seen;
  logic [11:0]   last_data;
  int            last_addr;
  logic [GW-1:0] last_bits;
  logic [11:0]   wq[$];
  int unsigned   rr;

  typedef struct {
    logic [2:0]  mode;
    logic [3:0]  thresh;
    logic [15:0] pix;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [15:0] mk(input logic [3:0] r, input logic [3:0] g,
                                     input logic [3:0] b);
    return {r, 1'b0, g, 2'b00, b, 1'b0};
  endfunction

  function automatic int san(input int m);
    return (m > 5) ? 0 : m;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit v, input bit fd, input logic [15:0] p);
    int x, y, cnt, r, g, b, lum;
    logic [11:0] d;
    e_wr_en = 0; e_rv = 0; e_gd = 0; e_short = 0;
    if (fd) begin
      e_short = (n > 0 && n < NPIX);
      n = 0; prev = '0; mode = san(int'(mode_in)); e_ovf = 0;
    end else if (v) begin
      if (n >= NPIX) e_ovf = 1;
      else begin
        r = int'(p[15:12]); g = int'(p[10:7]); b = int'(p[4:1]);
        lum = r / 4 + g / 2 + b / 4;
        case (mode)
          1: d = {4'(iabs(r - int'(prev[11:8]))), 4'(iabs(g - int'(prev[7:4]))),
                  4'(iabs(b - int'(prev[3:0])))};
          2: d = (r > 8 && g < 8 && b < 8) ? 12'hF00 : 12'h000;
          3: d = (g > 8 && r < 8 && b < 8) ? 12'h0F0 : 12'h000;
          4: d = (b > 8 && r < 8 && g < 8) ? 12'h00F : 12'h000;
          5: d = (lum > int'(thresh_in)) ? 12'hFFF : 12'h000;
          default: d = {p[15:12], p[10:7], p[4:1]};
        endcase
        x = n % H; y = n / H;
        dark_img[y][x] = (lum <= int'(thresh_in));
        e_wr_en = 1; e_addr = n; e_data = d;
        if (x == H - 1 && y % DS == DS - 1) begin
          e_rv = 1; e_idx = y / DS; e_gd = (y / DS == GH - 1);
          for (int c = 0; c < GW; c++) begin
            cnt = 0;
            for (int yy = y - DS + 1; yy <= y; yy++)
              for (int xx = c * DS; xx < (c + 1) * DS; xx++) cnt += int'(dark_img[yy][xx]);
            e_bits[c] = (2 * cnt > DS * DS);
          end
        end
        prev = {p[15:12], p[10:7], p[4:1]};
        n++;
      end
    end
  endtask

  // At a falling edge: check the previous cycle's outputs, then drive the next inputs.
  task automatic step(input bit v, input bit fd, input logic [15:0] p);
    chk("wr_en", bus.wr_en_out, e_wr_en);
    if (e_wr_en) begin
      chk("wr_addr", bus.wr_addr_out, e_addr);
      chk("wr_data", bus.wr_data_out, e_data);
    end
    chk("row_valid", row_valid_out, e_rv);
    chk("grid_done", grid_done_out, e_gd);
    chk("frame_short", frame_short_out, e_short);
    chk("overflow", overflow_out, e_ovf);
    chk("row_bits", row_bits_out, e_bits);
    chk("row_idx", row_idx_out, e_idx);
    if (bus.wr_en_out) begin
      writes_seen++; last_data = bus.wr_data_out; last_addr = int'(bus.wr_addr_out);
      wq.push_back(bus.wr_data_out);
    end
    if (row_valid_out) begin rows_seen++; last_bits = row_bits_out; end
    if (grid_done_out) gd_seen++;
    if (frame_short_out) short_seen++;
    bus.pixel_valid_in = v; bus.frame_done_in = fd; bus.pixel_in = p;
    model(v, fd, p);
    @(negedge pclk_in);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 16'h0);
  endtask

  task automatic new_frame(input int m, input int t);
    mode_in = 3'(m); thresh_in = 4'(t);
    step(0, 1, 16'h0);
    writes_seen = 0; rows_seen = 0; gd_seen = 0; short_seen = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.pixel_valid_in = 0; bus.frame_done_in = 0;
    repeat (3) @(negedge pclk_in);
    chk("rst_wr_en", bus.wr_en_out, 0);
    chk("rst_wr_addr", bus.wr_addr_out, 0);
    chk("rst_wr_data", bus.wr_data_out, 0);
    chk("rst_row_valid", row_valid_out, 0);
    chk("rst_grid_done", grid_done_out, 0);
    chk("rst_short", frame_short_out, 0);
    chk("rst_overflow", overflow_out, 0);
    chk("rst_row_bits", row_bits_out, 0);
    chk("rst_row_idx", row_idx_out, 0);
    reset = 1'b0;
    n = 0; prev = '0; mode = san(int'(mode_in));
    e_wr_en = 0; e_rv = 0; e_gd = 0; e_short = 0; e_ovf = 0; e_addr = 0; e_idx = 0;
    e_data = '0; e_bits = '0;
  endtask

  initial begin
    tbl[0]  = '{3'd0, 4'd5, mk(4'hA, 4'hB, 4'h2), 12'hAB2};
    tbl[1]  = '{3'd1, 4'd5, mk(4'h3, 4'h4, 4'h5), 12'h345};
    tbl[2]  = '{3'd2, 4'd5, mk(4'h9, 4'h7, 4'h7), 12'hF00};
    tbl[3]  = '{3'd2, 4'd5, mk(4'h8, 4'h0, 4'h0), 12'h000};
    tbl[4]  = '{3'd2, 4'd5, mk(4'h9, 4'h8, 4'h0), 12'h000};
    tbl[5]  = '{3'd3, 4'd5, mk(4'h0, 4'hF, 4'h7), 12'h0F0};
    tbl[6]  = '{3'd4, 4'd5, mk(4'h1, 4'h2, 4'hC), 12'h00F};
    tbl[7]  = '{3'd5, 4'd5, mk(4'hF, 4'hF, 4'hF), 12'hFFF};
    tbl[8]  = '{3'd5, 4'd5, mk(4'h4, 4'h4, 4'h4), 12'h000};
    tbl[9]  = '{3'd5, 4'd5, mk(4'h4, 4'h6, 4'h4), 12'h000};
    tbl[10] = '{3'd5, 4'd5, mk(4'h4, 4'h8, 4'h4), 12'hFFF};
    tbl[11] = '{3'd6, 4'd5, mk(4'h1, 4'h2, 4'h3), 12'h123};
    tbl[12] = '{3'd7, 4'd5, mk(4'hC, 4'hD, 4'hE), 12'hCDE};

    reset = 1'b1; mode_in = 3'd5; thresh_in = 4'd5;
    bus.pixel_in = '0; bus.pixel_valid_in = 0; bus.frame_done_in = 0;
    writes_seen = 0; rows_seen = 0; gd_seen = 0; short_seen = 0;
    @(negedge pclk_in);
    do_reset();

    foreach (tbl[i]) begin
      new_frame(int'(tbl[i].mode), int'(tbl[i].thresh));
      step(1, 0, tbl[i].pix);
      idle(1);
      chk("table_data", last_data, tbl[i].exp);
    end

    // Bright luma frame: two light rows then grid done.
    new_frame(5, 5);
    for (int i = 0; i < NPIX; i++) step(1, 0, 16'hFFFF);
    idle(2);
    chk("bright_rows", rows_seen, 2);
    chk("bright_grid_done", gd_seen, 1);
    chk("bright_writes", writes_seen, NPIX);
    chk("bright_bits", last_bits, 2'b00);

    new_frame(5, 5);
    for (int i = 0; i < NPIX; i++) step(1, 0, 16'h0000);
    idle(1);
    chk("dark_bits", last_bits, 2'b11);

    // 33 of 64 dark in the left cell, exactly 32 in the right cell.
    new_frame(5, 5);
    for (int y = 0; y < DS; y++)
      for (int x = 0; x < H; x++)
        step(1, 0, ((x < DS) ? (y * DS + x < 33) : (y * DS + x - DS < 32)) ? 16'h0 : 16'hFFFF);
    idle(1);
    chk("majority_bits", last_bits, 2'b01);
    for (int i = 0; i < NPIX / 2; i++) step(1, 0, 16'hFFFF);
    idle(1);

    new_frame(1, 5);
    wq.delete();
    step(1, 0, mk(4'h3, 4'h0, 4'h0));
    step(1, 0, mk(4'h9, 4'h0, 4'h0));
    step(1, 0, mk(4'h4, 4'h0, 4'h0));
    idle(1);
    chk("diff_count", wq.size(), 3);
    if (wq.size() == 3) begin
      chk("diff0", wq[0][11:8], 3);
      chk("diff1", wq[1][11:8], 6);
      chk("diff2", wq[2][11:8], 5);
    end
    new_frame(1, 5);
    step(1, 0, mk(4'h4, 4'h0, 4'h0));
    idle(1);
    chk("diff_prev_reset", last_data, 12'h400);

    new_frame(2, 5);
    for (int i = 0; i < 10; i++) step(1, 0, mk(4'h9, 4'h7, 4'h7));
    mode_in = 3'd5;
    for (int i = 0; i < 10; i++) step(1, 0, mk(4'h9, 4'h7, 4'h7));
    idle(1);
    chk("latch_hold", last_data, 12'hF00);
    new_frame(5, 5);
    step(1, 0, mk(4'h9, 4'h7, 4'h7));
    idle(1);
    chk("latch_next", last_data, 12'hFFF);

    new_frame(5, 5);
    for (int i = 0; i < 100; i++) step(1, 0, 16'h1234);
    idle(1);
    rows_seen = 0; short_seen = 0;
    step(0, 1, 16'h0);
    idle(1);
    chk("short_pulse", short_seen, 1);
    chk("short_no_row", rows_seen, 0);
    step(1, 0, 16'hFFFF);
    idle(1);
    chk("short_restart_addr", last_addr, 0);
    writes_seen = 0;
    step(1, 1, 16'hFFFF);
    idle(1);
    chk("fd_beats_pixel", writes_seen, 0);

    new_frame(5, 5);
    for (int i = 0; i < NPIX + 1; i++) step(1, 0, 16'hFFFF);
    idle(1);
    chk("ovf_set", overflow_out, 1);
    chk("ovf_writes", writes_seen, NPIX);
    step(0, 1, 16'h0);
    idle(1);
    chk("ovf_clear", overflow_out, 0);

    new_frame(0, 5);
    for (int i = 0; i < 50; i++) step(1, 0, 16'hABCD);
    do_reset();
    step(1, 0, 16'h5555);
    idle(1);
    chk("reset_restart_addr", last_addr, 0);

    for (int i = 0; i < 6000; i++) begin
      rr = $urandom_range(0, 999);
      if (rr < 3) begin
        mode_in = 3'($urandom_range(0, 7)); thresh_in = 4'($urandom_range(0, 15));
        step(1'($urandom_range(0, 1)), 1, 16'($urandom));
      end else if (rr < 800) begin
        step(1, 0, 16'($urandom));
      end else if (rr < 815) begin
        mode_in = 3'($urandom_range(0, 7)); thresh_in = 4'($urandom_range(0, 15));
        step(0, 0, 16'h0);
      end else begin
        step(0, 0, 16'($urandom));
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
